// File: rtl/bootrom_copy_pkg.sv
// Shared types and constants for the boot ROM copy engine.
package bootrom_copy_pkg;

    localparam int unsigned FIFO_DEPTH_DEF = 2;
    localparam int unsigned CNT_WIDTH_DEF  = 16;
    localparam int unsigned WORD_BYTES     = 8;
    localparam int unsigned ADDR_W         = 64;
    localparam int unsigned DATA_W         = 64;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE,
        RUN   = ST_RUN,
        DRAIN = ST_DRAIN,
        DONE  = ST_DONE
    } state_e;

    // Byte address of word idx counted from base; wraps modulo 2^64.
    function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] base,
                                                    input logic [ADDR_W-1:0] idx);
        return base + (idx * ADDR_W'(WORD_BYTES));
    endfunction

    // Force a byte address onto a word boundary.
    function automatic logic [ADDR_W-1:0] align_word(input logic [ADDR_W-1:0] a);
        return a & ~ADDR_W'(WORD_BYTES - 1);
    endfunction

endpackage

// File: rtl/bootrom_copy_fifo.sv
// Small synchronous FIFO buffering ROM read data ahead of the write port.
module bootrom_copy_fifo #(
    parameter int unsigned Depth = 2,
    parameter int unsigned Width = 64,
    localparam int unsigned PtrW = $clog2(Depth),
    localparam int unsigned CntW = PtrW + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [Width-1:0] wdata_i,
    input  logic             pop_i,
    output logic [Width-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CntW-1:0]  count_o
);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]  count_q;
    logic             do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CntW'(Depth));
    assign count_o = count_q;
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    // Head is forced to zero when empty so stale entries never leak out.
    assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

    // Storage array, written on accepted push.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    // Pointers and occupancy; power-of-two depth lets pointers wrap naturally.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
            count_q <= count_q + CntW'(do_push) - CntW'(do_pop);
        end
    end

`ifndef SYNTHESIS
    // Overflow guard: a push into a full FIFO without a same-cycle pop loses data.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            assert (!(push_i && full_o && !do_pop));
        end
    end
`endif

endmodule

// File: rtl/bootrom_copy_engine.sv
// Copies a block of 64-bit words from the boot ROM onto a valid/ready write port.
module bootrom_copy_engine
    import bootrom_copy_pkg::*;
#(
    parameter int unsigned FifoDepth = FIFO_DEPTH_DEF,
    parameter int unsigned CntWidth  = CNT_WIDTH_DEF
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                start_i,
    input  logic [63:0]         src_addr_i,
    input  logic [63:0]         dst_addr_i,
    input  logic [CntWidth-1:0] num_words_i,
    output logic                busy_o,
    output logic                done_o,
    output logic [CntWidth-1:0] words_done_o,
    output logic                rom_req_o,
    output logic [63:0]         rom_addr_o,
    input  logic [63:0]         rom_rdata_i,
    output logic                wr_valid_o,
    output logic [63:0]         wr_addr_o,
    output logic [63:0]         wr_data_o,
    input  logic                wr_ready_i
);

    localparam int unsigned FifoCntW = $clog2(FifoDepth) + 1;

    state_e                state_q, state_d;
    logic [63:0]           src_q, src_d, dst_q, dst_d;
    logic [CntWidth-1:0]   num_q, num_d;
    logic [CntWidth-1:0]   rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d;
    logic                  inflight_q;
    logic                  busy_q, busy_d, done_q, done_d;
    logic                  rom_req_c, fifo_pop_c;
    logic                  fifo_full, fifo_empty;
    logic [FifoCntW-1:0]   fifo_count;
    logic [63:0]           fifo_rdata;
    logic [31:0]           occ_c;

    assign fifo_pop_c = !fifo_empty && wr_ready_i;
    // Slots committed after this cycle: buffered + in flight - leaving now.
    assign occ_c = 32'(fifo_count) + 32'(inflight_q) - 32'(fifo_pop_c);

    bootrom_copy_fifo #(
        .Depth (FifoDepth),
        .Width (DATA_W)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (inflight_q),
        .wdata_i (rom_rdata_i),
        .pop_i   (fifo_pop_c),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // Next-state, counter and ROM request logic.
    always_comb begin
        state_d   = state_q;
        src_d     = src_q;
        dst_d     = dst_q;
        num_d     = num_q;
        rd_cnt_d  = rd_cnt_q;
        wr_cnt_d  = wr_cnt_q + CntWidth'(fifo_pop_c);
        rom_req_c = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    src_d    = align_word(src_addr_i);
                    dst_d    = align_word(dst_addr_i);
                    num_d    = num_words_i;
                    rd_cnt_d = '0;
                    wr_cnt_d = '0;
                    state_d  = (num_words_i == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                rom_req_c = (rd_cnt_q < num_q) && (occ_c < FifoDepth);
                if (rom_req_c) begin
                    rd_cnt_d = rd_cnt_q + CntWidth'(1);
                end
                if (rd_cnt_q == num_q) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (wr_cnt_d == num_q) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    // State, latched transfer parameters, counters and registered status.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            src_q      <= '0;
            dst_q      <= '0;
            num_q      <= '0;
            rd_cnt_q   <= '0;
            wr_cnt_q   <= '0;
            inflight_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            src_q      <= src_d;
            dst_q      <= dst_d;
            num_q      <= num_d;
            rd_cnt_q   <= rd_cnt_d;
            wr_cnt_q   <= wr_cnt_d;
            inflight_q <= rom_req_c;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign words_done_o = wr_cnt_q;
    assign rom_req_o    = rom_req_c;
    assign rom_addr_o   = word_addr(src_q, 64'(rd_cnt_q));
    assign wr_valid_o   = !fifo_empty;
    assign wr_addr_o    = word_addr(dst_q, 64'(wr_cnt_q));
    assign wr_data_o    = fifo_rdata;

`ifndef SYNTHESIS
    logic        hold_q;
    logic [63:0] hold_addr_q, hold_data_q;

    // Protocol checks: aligned ROM address, no FIFO overrun, write beat stable until taken.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hold_q      <= 1'b0;
            hold_addr_q <= '0;
            hold_data_q <= '0;
        end else begin
            assert (!rom_req_o || (rom_addr_o[2:0] == 3'b000));
            assert (!(inflight_q && fifo_full && !fifo_pop_c));
            if (hold_q) begin
                assert (wr_valid_o && (wr_addr_o == hold_addr_q) && (wr_data_o == hold_data_q));
            end
            hold_q      <= wr_valid_o && !wr_ready_i;
            hold_addr_q <= wr_addr_o;
            hold_data_q <= wr_data_o;
        end
    end
`endif

endmodule

// File: tb/tb_bootrom_copy_engine.sv
// Scoreboard bench for bootrom_copy_engine: randomized transfers against a word-list reference.
module tb_bootrom_copy_engine;

    localparam int unsigned FD = 2;
    localparam int unsigned CW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [63:0]   src_addr, dst_addr;
    logic [CW-1:0] num_words;
    logic          busy, done;
    logic [CW-1:0] words_done;
    logic          rom_req;
    logic [63:0]   rom_addr;
    logic [63:0]   rom_rdata = 64'h0;
    logic          wr_valid;
    logic [63:0]   wr_addr, wr_data;
    logic          wr_ready;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int start_cyc = 0;
    int mode = 0;
    int beats_acc = 0;

    typedef struct {
        logic [63:0] addr;
        logic [63:0] data;
    } beat_t;

    typedef struct {
        int words;
        bit chk_time;
        int exp_cyc;
    } done_t;

    beat_t exp_beats[$];
    done_t exp_done[$];

    bootrom_copy_engine #(.FifoDepth(FD), .CntWidth(CW)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .start_i      (start),
        .src_addr_i   (src_addr),
        .dst_addr_i   (dst_addr),
        .num_words_i  (num_words),
        .busy_o       (busy),
        .done_o       (done),
        .words_done_o (words_done),
        .rom_req_o    (rom_req),
        .rom_addr_o   (rom_addr),
        .rom_rdata_i  (rom_rdata),
        .wr_valid_o   (wr_valid),
        .wr_addr_o    (wr_addr),
        .wr_data_o    (wr_data),
        .wr_ready_i   (wr_ready)
    );

    function automatic logic [63:0] rom_word(input logic [63:0] a);
        return (a >> 3) + 64'h100;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%h expected=%h", name, act, exp);
        end
    endtask

    initial forever #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // ROM model: one-cycle read latency, garbage when not requested.
    always @(posedge clk) begin
        rom_rdata <= rom_req ? rom_word(rom_addr) : 64'hBAD0_BAD0_BAD0_BAD0;
    end

    // Write-side backpressure: 0 always ready, 1 random, 2 stalled for 10 cycles after start.
    initial begin
        wr_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (mode)
                0:       wr_ready = 1'b1;
                1:       wr_ready = 1'($urandom_range(0, 1));
                default: wr_ready = ((cyc - start_cyc) >= 10);
            endcase
        end
    end

    // Monitor: checks every accepted beat and every done pulse against the queues.
    initial begin : monitor
        bit          hold;
        logic [63:0] h_addr, h_data;
        int          outst;
        beat_t       b;
        done_t       d;
        hold = 1'b0;
        h_addr = '0;
        h_data = '0;
        outst = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                hold = 1'b0;
                outst = 0;
                continue;
            end
            if (hold) begin
                chk("hold_valid", 64'(wr_valid), 64'd1);
                chk("hold_addr", wr_addr, h_addr);
                chk("hold_data", wr_data, h_data);
            end
            hold = wr_valid && !wr_ready;
            h_addr = wr_addr;
            h_data = wr_data;
            if (rom_req) outst++;
            if (wr_valid && wr_ready) begin
                outst--;
                beats_acc++;
                if (exp_beats.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_beat: actual addr=%h data=%h expected none", wr_addr, wr_data);
                end else begin
                    b = exp_beats.pop_front();
                    chk("beat_addr", wr_addr, b.addr);
                    chk("beat_data", wr_data, b.data);
                end
            end
            if (rom_req) chk("outstanding_le_depth", 64'(outst <= int'(FD)), 64'd1);
            if (done) begin
                if (exp_done.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_done: actual done_o=1 expected 0 at cycle %0d", cyc);
                end else begin
                    d = exp_done.pop_front();
                    chk("words_done_at_done", 64'(words_done), 64'(d.words));
                    chk("beats_left_at_done", 64'(exp_beats.size()), 64'd0);
                    if (d.chk_time) chk("done_cycle", 64'(cyc), 64'(d.exp_cyc));
                end
            end
        end
    end

    task automatic push_expect(input logic [63:0] src, input logic [63:0] dst, input int num);
        logic [63:0] s, dd;
        beat_t bb;
        s  = src & ~64'h7;
        dd = dst & ~64'h7;
        for (int k = 0; k < num; k++) begin
            bb.addr = dd + 64'(k) * 64'd8;
            bb.data = rom_word(s + 64'(k) * 64'd8);
            exp_beats.push_back(bb);
        end
    endtask

    task automatic run_xfer(input logic [63:0] src, input logic [63:0] dst, input int num,
                            input int md, input bit hold_start);
        done_t de;
        bit    got;
        int    act;
        mode = md;
        repeat (2) @(posedge clk);
        #1;
        push_expect(src, dst, num);
        start     = 1'b1;
        src_addr  = src;
        dst_addr  = dst;
        num_words = CW'(num);
        @(posedge clk);
        #1;
        start_cyc = cyc;
        if (!hold_start) start = 1'b0;
        de.words    = num;
        de.chk_time = (md == 0);
        de.exp_cyc  = start_cyc + ((num == 0) ? 0 : num + 2);
        exp_done.push_back(de);
        chk("busy_after_start", 64'(busy), 64'd1);
        got = 1'b0;
        act = 0;
        for (int i = 0; i < 3000 && !got; i++) begin
            @(negedge clk);
            if (rom_req || wr_valid) act++;
            if (done) got = 1'b1;
        end
        if (!got) begin
            total++;
            bad++;
            $display("FAIL done_timeout: actual no done_o expected done for num=%0d", num);
        end
        if (num == 0) chk("num0_no_activity", 64'(act), 64'd0);
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("idle_busy", 64'(busy), 64'd0);
        chk("idle_words_hold", 64'(words_done), 64'(num));
        chk("idle_no_valid", 64'(wr_valid), 64'd0);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: actual still running expected finished");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int base;
        rst       = 1'b1;
        start     = 1'b0;
        src_addr  = '0;
        dst_addr  = '0;
        num_words = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_words", 64'(words_done), 64'd0);
        chk("rst_rom_req", 64'(rom_req), 64'd0);
        chk("rst_wr_valid", 64'(wr_valid), 64'd0);
        rst = 1'b0;

        run_xfer(64'h0, 64'h8000_0000, 4, 0, 1'b0);
        run_xfer(64'h1234, 64'h5678, 0, 0, 1'b0);
        run_xfer(64'h100, 64'h9000, 8, 2, 1'b0);
        run_xfer(64'h40, 64'hA000_0000, 64, 1, 1'b0);

        // Reset in the middle of a transfer.
        mode = 0;
        repeat (2) @(posedge clk);
        #1;
        push_expect(64'h200, 64'h1000, 20);
        base      = beats_acc;
        start     = 1'b1;
        src_addr  = 64'h200;
        dst_addr  = 64'h1000;
        num_words = CW'(20);
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int i = 0; i < 200 && beats_acc < base + 3; i++) @(negedge clk);
        chk("beats_before_reset", 64'(beats_acc >= base + 3), 64'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        exp_beats.delete();
        exp_done.delete();
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_done", 64'(done), 64'd0);
        chk("mid_rst_words", 64'(words_done), 64'd0);
        chk("mid_rst_rom_req", 64'(rom_req), 64'd0);
        chk("mid_rst_rom_addr", rom_addr, 64'd0);
        chk("mid_rst_wr_valid", 64'(wr_valid), 64'd0);
        chk("mid_rst_wr_addr", wr_addr, 64'd0);
        chk("mid_rst_wr_data", wr_data, 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        run_xfer(64'h808, 64'h2000, 2, 0, 1'b0);

        // start_i held through the whole transfer including DONE.
        run_xfer(64'h300, 64'h4000, 5, 0, 1'b1);

        // Address wrap around 2^64 with unaligned inputs.
        run_xfer(64'hFFFF_FFFF_FFFF_FFE5, 64'hFFFF_FFFF_FFFF_FFF3, 6, 0, 1'b0);

        for (int t = 0; t < 6; t++) begin
            run_xfer({$urandom, $urandom}, {$urandom, $urandom}, int'($urandom_range(1, 24)),
                     int'($urandom_range(0, 1)), 1'b0);
        end

        repeat (4) @(posedge clk);
        #1;
        chk("final_queue_empty", 64'(exp_beats.size() + exp_done.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
